seg_value_ctrl: RTL and testbench

//  Converts a binary value into three 7-segment digit patterns for the 3-digit display scanner.

---
 rtl/seg_value_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg_value_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_value_ctrl.sv
// Binary-to-3-digit 7-segment converter: sequential double-dabble (one step per clock), then encode.
// Patterns are active-low {dp,g..a}; outputs hold until the ENCODE edge, which also pulses upd_done.
module seg_value_ctrl #(
  parameter int VAL_W    = 10,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_value,
  input  logic [1:0]       in_dp,
  output logic [7:0]       seg_data_0,
  output logic [7:0]       seg_data_1,
  output logic [7:0]       seg_data_2,
  output logic             busy,
  output logic             upd_done
);

  localparam int CNT_W = $clog2(VAL_W);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_ENCODE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [VAL_W-1:0]    r_val;
  logic [11:0]         r_bcd;
  logic [CNT_W-1:0]    r_cnt;
  logic [1:0]          r_dp;
  logic                r_ovf;
  logic [7:0]          r_seg0, r_seg1, r_seg2;
  logic                r_upd;
  logic [11:0]         w_adj;
  logic [12+VAL_W-1:0] w_sh;
  logic [7:0]          w_pat0, w_pat1, w_pat2;

  function automatic logic [7:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    f_seg = 8'hC0;
      4'd1:    f_seg = 8'hF9;
      4'd2:    f_seg = 8'hA4;
      4'd3:    f_seg = 8'hB0;
      4'd4:    f_seg = 8'h99;
      4'd5:    f_seg = 8'h92;
      4'd6:    f_seg = 8'h82;
      4'd7:    f_seg = 8'hF8;
      4'd8:    f_seg = 8'h80;
      4'd9:    f_seg = 8'h90;
      default: f_seg = 8'hFF;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (in_valid) w_next = S_SHIFT;
      S_SHIFT:  if (r_cnt == CNT_W'(VAL_W - 1)) w_next = S_ENCODE;
      S_ENCODE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = ~in_ready;
  end

  // Add-3 on every nibble >= 5 before the shift, all nibbles in parallel
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_sh = {w_adj, r_val} << 1;
  end

  always_comb begin
    w_pat0 = f_seg(r_bcd[11:8]);
    w_pat1 = f_seg(r_bcd[7:4]);
    w_pat2 = f_seg(r_bcd[3:0]);
    if (BLANK_LZ && (r_bcd[11:8] == 4'd0)) begin
      w_pat0 = 8'hFF;
      if (r_bcd[7:4] == 4'd0) w_pat1 = 8'hFF;
    end
    if (r_ovf) begin
      w_pat0 = 8'hBF;
      w_pat1 = 8'hBF;
      w_pat2 = 8'hBF;
    end
    case (r_dp)
      2'd1:    w_pat0[7] = 1'b0;
      2'd2:    w_pat1[7] = 1'b0;
      2'd3:    w_pat2[7] = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val  <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_dp   <= '0;
      r_ovf  <= 1'b0;
      r_seg0 <= 8'hFF;
      r_seg1 <= 8'hFF;
      r_seg2 <= 8'hFF;
      r_upd  <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_val <= in_value;
          r_dp  <= in_dp;
          r_ovf <= (32'(in_value) > 32'd999);
          r_bcd <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_bcd <= w_sh[12+VAL_W-1:VAL_W];
          r_val <= w_sh[VAL_W-1:0];
          r_cnt <= r_cnt + 1'b1;
        end
        S_ENCODE: begin
          r_seg0 <= w_pat0;
          r_seg1 <= w_pat1;
          r_seg2 <= w_pat2;
          r_upd  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign seg_data_0 = r_seg0;
  assign seg_data_1 = r_seg1;
  assign seg_data_2 = r_seg2;
  assign upd_done   = r_upd;

endmodule

// File: tb/tb_seg_value_ctrl.sv
module tb_seg_value_ctrl;
  localparam int VW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_value = '0;
  logic [1:0]    in_dp = '0;
  logic          ready_a, busy_a, upd_a, ready_b, busy_b, upd_b;
  logic [7:0]    a0, a1, a2, b0, b1, b2;

  seg_value_ctrl #(.VAL_W(VW), .BLANK_LZ(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_a), .in_value(in_value),
    .in_dp(in_dp), .seg_data_0(a0), .seg_data_1(a1), .seg_data_2(a2), .busy(busy_a),
    .upd_done(upd_a));

  seg_value_ctrl #(.VAL_W(VW), .BLANK_LZ(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ready_b), .in_value(in_value),
    .in_dp(in_dp), .seg_data_0(b0), .seg_data_1(b1), .seg_data_2(b2), .busy(busy_b),
    .upd_done(upd_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [23:0] ea;
    logic [23:0] eb;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [23:0] shown_a = 24'hFFFFFF;
  logic [23:0] shown_b = 24'hFFFFFF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] digit(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  default: return 8'h90;
    endcase
  endfunction

  // Decimal arithmetic reference: hundreds/tens/units straight from division
  function automatic logic [23:0] model(input int v, input int dp, input bit blz);
    logic [7:0] d [3];
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    if (v > 999) begin
      d[0] = 8'hBF; d[1] = 8'hBF; d[2] = 8'hBF;
    end else begin
      d[0] = (blz && h == 0) ? 8'hFF : digit(h);
      d[1] = (blz && h == 0 && t == 0) ? 8'hFF : digit(t);
      d[2] = digit(u);
    end
    if (dp != 0) d[dp-1][7] = 1'b0;
    return {d[0], d[1], d[2]};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (upd_a || upd_b) begin
      if (sb.size() == 0) begin
        check("spurious_upd", {30'd0, upd_a, upd_b}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("seg_lz1", {8'd0, a0, a1, a2}, {8'd0, e.ea});
        check("seg_lz0", {8'd0, b0, b1, b2}, {8'd0, e.eb});
        check("upd_lz1", {31'd0, upd_a}, 32'd1);
        check("upd_lz0", {31'd0, upd_b}, 32'd1);
        check("latency", cyc - e.acc, VW + 1);
        shown_a = e.ea;
        shown_b = e.eb;
      end
    end else begin
      check("hold_lz1", {8'd0, a0, a1, a2}, {8'd0, shown_a});
      check("hold_lz0", {8'd0, b0, b1, b2}, {8'd0, shown_b});
      check("busy_inv", {31'd0, busy_a}, {31'd0, ~ready_a});
      if (sb.size() > 0 && (cyc - sb[0].acc) > VW + 3) begin
        check("timeout", cyc - sb[0].acc, VW + 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int v, input int dp);
    exp_t e;
    e.ea  = model(v, dp, 1'b1);
    e.eb  = model(v, dp, 1'b0);
    e.acc = cyc + 1;
    sb.push_back(e);
  endtask

  // Present a value until accepted; with hold=1 in_valid stays high afterwards
  task automatic offer(input int v, input int dp, input bit hold);
    int n;
    in_valid = 1'b1;
    in_value = VW'(v);
    in_dp    = 2'(dp);
    n = 0;
    while (!ready_a && n < 100) begin
      step();
      n++;
    end
    if (!ready_a) check("ready_wait", {31'd0, ready_a}, 32'd1);
    push(v, dp);
    step();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_seg"}, {8'd0, a0, a1, a2}, 32'h00FFFFFF);
    check({tag, "_ready"}, {31'd0, ready_a}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy_a}, 32'd0);
    check({tag, "_upd"}, {31'd0, upd_a}, 32'd0);
  endtask

  task automatic mid_reset(input int v);
    int k;
    offer(v, 0, 1'b0);
    k = $urandom_range(1, VW - 1);
    repeat (k - 1) step();
    rst = 1'b1;
    sb.delete();
    step();
    rst = 1'b0;
    shown_a = 24'hFFFFFF;
    shown_b = 24'hFFFFFF;
    check_idle_reset("midrst");
    step();
  endtask

  initial begin
    int v, dp, n;
    step();
    step();
    rst = 1'b0;
    check_idle_reset("reset");

    offer(0, 0, 1'b0);
    offer(42, 0, 1'b0);
    offer(105, 0, 1'b0);
    offer(999, 0, 1'b0);
    offer(7, 0, 1'b0);
    offer(1000, 0, 1'b0);
    offer(1023, 2, 1'b0);
    offer(5, 3, 1'b0);
    offer(5, 1, 1'b0);
    offer(12, 0, 1'b1);
    offer(34, 0, 1'b0);
    repeat (VW + 4) step();

    mid_reset(987);
    offer(321, 2, 1'b0);

    for (int i = 0; i < 1500; i++) begin
      if (ready_a) begin
        if ($urandom_range(0, 2) != 0) begin
          case ($urandom_range(0, 3))
            0:       v = $urandom_range(0, 9);
            1:       v = $urandom_range(10, 99);
            2:       v = $urandom_range(100, 999);
            default: v = $urandom_range(0, 1023);
          endcase
          dp = $urandom_range(0, 3);
          in_valid = 1'b1;
          in_value = VW'(v);
          in_dp    = 2'(dp);
          push(v, dp);
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        in_valid = 1'($urandom_range(0, 1));
        in_value = VW'($urandom);
        in_dp    = 2'($urandom);
      end
      step();
      if (i == 700) begin
        in_valid = 1'b0;
        mid_reset($urandom_range(0, 1023));
      end
    end

    in_valid = 1'b0;
    n = 0;
    while (sb.size() > 0 && n < 4 * VW) begin
      step();
      n++;
    end
    check("drain", sb.size(), 0);
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
